// File: rtl/trace_byte_packer.sv
// Trace word FIFO + byte serialiser: each {tag,payload} word becomes a header-first byte record.
// Optional timestamping is enabled with the TRACE_PACK_TS_EN macro (52-bit entries, 7-byte records).
module trace_byte_packer #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_valid,
  input  logic [35:0]           trace_data,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

`ifdef TRACE_PACK_TS_EN
  localparam int         W       = 52;
  localparam logic [3:0] HDR_NIB = 4'hB;
`else
  localparam int         W       = 36;
  localparam logic [3:0] HDR_NIB = 4'hA;
`endif

  typedef enum logic [2:0] {IDLE, HDR, B0, B1, B2, B3, TS0, TS1} state_t;

  state_t                state_q;
  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          hold_q;
  logic [W-1:0]          head;
  logic [W-1:0]          wr_word;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [7:0]            out_data_q;
  logic                  overflow_q;
  logic [15:0]           drop_q;
  logic                  full, empty, wr_en, drop, fire, rec_end, pop;

`ifdef TRACE_PACK_TS_EN
  logic [15:0] ts_q;

  // Free-running stamp; deliberately untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 16'd1;
  end

  assign wr_word = {ts_q, trace_data};
  assign rec_end = out_valid_q && out_ready && (state_q == TS1);
`else
  assign wr_word = trace_data;
  assign rec_end = out_valid_q && out_ready && (state_q == B3);
`endif

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = trace_valid && !flush && !full;
  assign drop  = trace_valid && !flush && full;
  assign fire  = out_valid_q && out_ready;
  assign pop   = !flush && !empty && ((state_q == IDLE) || rec_end);
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_q + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(pop);

      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end

      // A pop always starts a fresh record, which keeps back-to-back records gapless.
      if (pop) begin
        hold_q      <= head;
        state_q     <= HDR;
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
        out_data_q  <= {HDR_NIB, head[35:32]};
      end else if (rec_end) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (fire) begin
        case (state_q)
          HDR: begin
            state_q    <= B0;
            out_data_q <= hold_q[7:0];
          end
          B0: begin
            state_q    <= B1;
            out_data_q <= hold_q[15:8];
          end
          B1: begin
            state_q    <= B2;
            out_data_q <= hold_q[23:16];
          end
          B2: begin
            state_q    <= B3;
            out_data_q <= hold_q[31:24];
`ifndef TRACE_PACK_TS_EN
            out_last_q <= 1'b1;
`endif
          end
`ifdef TRACE_PACK_TS_EN
          B3: begin
            state_q    <= TS0;
            out_data_q <= hold_q[43:36];
          end
          TS0: begin
            state_q    <= TS1;
            out_data_q <= hold_q[51:44];
            out_last_q <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_byte_packer.sv
// Directed bench for trace_byte_packer: a byte scoreboard checks every accepted byte,
// directed checks cover latency, backpressure, overflow, flush and async reset.
`timescale 1ns/1ps
module tb_trace_byte_packer;

`ifdef TRACE_PACK_TS_EN
  localparam logic [3:0] HNIB    = 4'hB;
  localparam int         REC_LEN = 7;
`else
  localparam logic [3:0] HNIB    = 4'hA;
  localparam int         REC_LEN = 5;
`endif

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        trace_valid = 1'b0;
  logic        flush       = 1'b0;
  logic        out_ready   = 1'b0;
  logic [35:0] trace_data  = '0;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];   // {sentinel, last, byte}
  logic [15:0] tb_ts;

  trace_byte_packer #(.DEPTH(16), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_data(trace_data),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_record(input logic [35:0] d, input logic [15:0] ts);
    logic l;
    exp_q.push_back({2'b00, HNIB, d[35:32]});
    for (int i = 0; i < 4; i++) begin
      l = (i == 3) && (REC_LEN == 5);
      exp_q.push_back({1'b0, l, d[8*i +: 8]});
    end
`ifdef TRACE_PACK_TS_EN
    exp_q.push_back({2'b00, ts[7:0]});
    exp_q.push_back({2'b01, ts[15:8]});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [35:0] d, input bit accept);
    trace_valid = 1'b1;
    trace_data  = d;
    if (accept) push_record(d, tb_ts);
    step();
    trace_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      step();
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 10'h3FF;
      check("sb_byte", {22'd0, 1'b0, out_last, out_data}, {22'd0, e});
    end
  end

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Single word: header two cycles after the write, record then idle.
    send(36'h1_DEADBEEF, 1'b1);
    check("t1_n1_valid", out_valid, 0);
    step();
    check("t1_hdr_valid", out_valid, 1);
    check("t1_hdr_data", out_data, {24'd0, HNIB, 4'h1});
    repeat (REC_LEN) step();
    check("t1_end_valid", out_valid, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Backpressure while BE is presented.
    send(36'h1_DEADBEEF, 1'b1);
    step();
    step();
    step();
    check("t2_be", out_data, 8'hBE);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_data", out_data, 8'hBE);
      check("t2_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drain("t2_drain");

    // Overflow: 20 words, 17 fit (1 holding + 16 FIFO).
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send({4'(i), 32'(32'hC0DE0000 + i)}, i < 17);
    check("t3_level", fifo_level, 16);
    check("t3_drop", drop_count, 3);
    check("t3_ovf", overflow, 1);
    out_ready = 1'b1;
    drain("t3_drain");

    // Back-to-back records with no gap.
    send(36'h2_11223344, 1'b1);
    send(36'h3_55667788, 1'b1);
    for (int i = 0; i < 2 * REC_LEN; i++) begin
      check("t4_contig", out_valid, 1);
      step();
    end
    check("t4_end_valid", out_valid, 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Flush while B1 is presented with 3 words queued; same-cycle write ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({4'h4, 32'(32'hF0000000 + i)}, 1'b1);
    check("t5_level", fifo_level, 3);
    out_ready = 1'b1;
    step();
    step();
    check("t5_b1", out_data, 8'h00);
    flush = 1'b1;
    trace_valid = 1'b1;
    trace_data = 36'hF_FFFFFFFF;
    step();
    flush = 1'b0;
    trace_valid = 1'b0;
    exp_q.delete();
    check("t5_valid", out_valid, 0);
    check("t5_last", out_last, 0);
    check("t5_level0", fifo_level, 0);
    check("t5_drop0", drop_count, 0);
    check("t5_ovf0", overflow, 0);
    step();
    check("t5_ignored_valid", out_valid, 0);
    check("t5_ignored_level", fifo_level, 0);
    send(36'h8_12345678, 1'b1);
    step();
    check("t5_clean_hdr", out_data, {24'd0, HNIB, 4'h8});
    drain("t5_drain");

    // Asynchronous reset mid-record during B2.
    send(36'h2_CAFEF00D, 1'b1);
    step();
    step();
    step();
    step();
    check("t6_b2", out_data, 8'hFE);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_async_valid", out_valid, 0);
    check("t6_async_last", out_last, 0);
    check("t6_async_level", fifo_level, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send(36'h3_00000042, 1'b1);
    drain("t6_post_rst");

`ifdef TRACE_PACK_TS_EN
    begin
      int k = 0;
      while (tb_ts != 16'h0123 && k < 1000) begin
        step();
        k++;
      end
      check("ts_wait", tb_ts, 16'h0123);
      send(36'h1_DEADBEEF, 1'b1);
      drain("ts_drain");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
